// File: rtl/pdm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pdm_pkg : shared widths, constants and saturation helper for pdm_cic_decim  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package pdm_pkg;

    localparam int OUT_W_DEF = 16;
    localparam int DCB_SHIFT = 10;

    // Register growth of the CIC: one input bit plus log2(DECIM) per stage.
    function automatic int cic_width(input int decim, input int order);
        return 1 + order * $clog2(decim);
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_cic_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pdm_cic_chan : one channel of CIC integrators, combs, scaling, saturation,  |
// | plus optional DC blocker when PDM_DC_BLOCK_EN is defined.  Rev 1.0          |
// +-----------------------------------------------------------------------------+
module pdm_cic_chan
    import pdm_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int ORDER = 4,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    bit_i,
    input  logic                    stb_i,
    output logic signed [OUT_W-1:0] sample_o
);

    localparam int W     = cic_width(DECIM, ORDER);
    // A +/-1 input needs two signed bits, so the exact result +/-DECIM^ORDER
    // only fits with one guard bit above W.
    localparam int ACC_W = W + 1;
    localparam int SHIFT = W - OUT_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t integ_q [ORDER];
    acc_t integ_d [ORDER];
    acc_t comb_q  [ORDER];
    acc_t comb_d  [ORDER];
    acc_t dly_q   [ORDER];
    acc_t dly_d   [ORDER];
    acc_t step_w;
    acc_t shift_w;
    logic signed [OUT_W-1:0] scaled_w;

    always_comb begin
        step_w  = bit_i ? acc_t'(1) : acc_t'(-1);
        integ_d = integ_q;
        comb_d  = comb_q;
        dly_d   = dly_q;
        if (en_i) begin
            integ_d[0] = integ_q[0] + step_w;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
        // Each comb reads the previous stage's register, forming a pipeline.
        if (stb_i) begin
            dly_d[0]  = integ_q[ORDER-1];
            comb_d[0] = integ_q[ORDER-1] - dly_q[0];
            for (int k = 1; k < ORDER; k++) begin
                dly_d[k]  = comb_q[k-1];
                comb_d[k] = comb_q[k-1] - dly_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            integ_q <= integ_d;
            comb_q  <= comb_d;
            dly_q   <= dly_d;
        end
    end

    assign shift_w  = comb_q[ORDER-1] >>> SHIFT;
    assign scaled_w = OUT_W'(sat_s(64'(shift_w), OUT_W));

`ifdef PDM_DC_BLOCK_EN
    logic                    dcb_en_q;
    logic signed [OUT_W-1:0] dcb_x_q;
    logic signed [OUT_W-1:0] dcb_x_d;
    logic signed [OUT_W-1:0] dcb_y_q;
    logic signed [OUT_W-1:0] dcb_y_d;
    logic signed [63:0]      dcb_sum_w;

    always_comb begin
        dcb_sum_w = 64'(scaled_w) - 64'(dcb_x_q) + 64'(dcb_y_q) - (64'(dcb_y_q) >>> DCB_SHIFT);
        dcb_x_d   = dcb_x_q;
        dcb_y_d   = dcb_y_q;
        if (dcb_en_q) begin
            dcb_x_d = scaled_w;
            dcb_y_d = OUT_W'(sat_s(dcb_sum_w, OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcb_en_q <= 1'b0;
            dcb_x_q  <= '0;
            dcb_y_q  <= '0;
        end else begin
            dcb_en_q <= stb_i;
            dcb_x_q  <= dcb_x_d;
            dcb_y_q  <= dcb_y_d;
        end
    end

    assign sample_o = dcb_y_q;
`else
    assign sample_o = scaled_w;
`endif

endmodule
`default_nettype wire

// File: rtl/pdm_cic_decim.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pdm_cic_decim : stereo PDM-to-PCM CIC decimator with valid/ready output,    |
// | single-entry buffer and overrun pulse. Option: PDM_DC_BLOCK_EN.  Rev 1.0    |
// +-----------------------------------------------------------------------------+
module pdm_cic_decim
    import pdm_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int ORDER = 4,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pdm_en,
    input  logic                    pdm_L,
    input  logic                    pdm_R,
    output logic signed [OUT_W-1:0] pcm_L,
    output logic signed [OUT_W-1:0] pcm_R,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    pcm_overrun
);

    localparam int CNT_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(ORDER + 1);

    logic [CNT_W-1:0]        dec_cnt_q;
    logic [CNT_W-1:0]        dec_cnt_d;
    logic                    dec_stb_q;
    logic                    dec_stb_d;
    logic                    comb_vld_q;
    logic [WARM_W-1:0]       warm_q;
    logic [WARM_W-1:0]       warm_d;
    logic                    res_vld_w;
    logic                    load_w;
    logic signed [OUT_W-1:0] sample_l_w;
    logic signed [OUT_W-1:0] sample_r_w;
    logic signed [OUT_W-1:0] pcm_l_q;
    logic signed [OUT_W-1:0] pcm_l_d;
    logic signed [OUT_W-1:0] pcm_r_q;
    logic signed [OUT_W-1:0] pcm_r_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    overrun_q;
    logic                    overrun_d;

    pdm_cic_chan #(.DECIM(DECIM), .ORDER(ORDER), .OUT_W(OUT_W)) u_chan_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (pdm_en),
        .bit_i    (pdm_L),
        .stb_i    (dec_stb_q),
        .sample_o (sample_l_w)
    );

    pdm_cic_chan #(.DECIM(DECIM), .ORDER(ORDER), .OUT_W(OUT_W)) u_chan_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (pdm_en),
        .bit_i    (pdm_R),
        .stb_i    (dec_stb_q),
        .sample_o (sample_r_w)
    );

`ifdef PDM_DC_BLOCK_EN
    logic dcb_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcb_vld_q <= 1'b0;
        else        dcb_vld_q <= comb_vld_q;
    end

    assign res_vld_w = dcb_vld_q;
`else
    assign res_vld_w = comb_vld_q;
`endif

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        dec_stb_d = 1'b0;
        warm_d    = warm_q;
        load_w    = 1'b0;
        pcm_l_d   = pcm_l_q;
        pcm_r_d   = pcm_r_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (pdm_en) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
            dec_stb_d = (dec_cnt_q == CNT_W'(DECIM - 1));
        end
        // The first ORDER results come from partially filled comb history.
        if (res_vld_w) begin
            if (warm_q == WARM_W'(ORDER)) load_w = 1'b1;
            else                          warm_d = warm_q + WARM_W'(1);
        end
        if (load_w) begin
            pcm_l_d   = sample_l_w;
            pcm_r_d   = sample_r_w;
            valid_d   = 1'b1;
            overrun_d = valid_q && !pcm_ready;
        end else if (valid_q && pcm_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q  <= '0;
            dec_stb_q  <= 1'b0;
            comb_vld_q <= 1'b0;
            warm_q     <= '0;
            pcm_l_q    <= '0;
            pcm_r_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            dec_stb_q  <= dec_stb_d;
            comb_vld_q <= dec_stb_q;
            warm_q     <= warm_d;
            pcm_l_q    <= pcm_l_d;
            pcm_r_q    <= pcm_r_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pcm_L       = pcm_l_q;
    assign pcm_R       = pcm_r_q;
    assign pcm_valid   = valid_q;
    assign pcm_overrun = overrun_q;

endmodule
`default_nettype wire
